mm_st_ctx_arb: RTL and testbench

//  N-context successor of the two-context (front/shadow) MM-to-ST arbiter. Each context has its own

---
 rtl/mm_st_ctx_arb.sv | 256 +++++++++++++++++++++++++
 tb/tb_mm_st_ctx_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_st_ctx_arb.sv
// Purpose: per-context request FIFOs arbitrated onto one Avalon-MM master; read data routed back through an in-order tag FIFO.
// Latency: push->eligible 1 cycle; command driven combinationally from the granted FIFO head; readdatavalid->return FIFO next edge.
// Backpressure: o_req_ready low when the selected request FIFO is full (strobe dropped); i_waitrequest freezes grant and command; reads wait for a tag slot and return credit.
// Build option: define MM_ST_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible ctx id wins) instead of round-robin.

`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif

// Generic show-ahead FIFO with synchronous reset.
// Latency: write visible at rd_dat the edge after wr_vld; rd_dat always shows the head.
// Backpressure: writes while full and reads while empty are ignored. Depth must be a power of two.
module mm_st_ctx_arb_fifo #(
    parameter int p_width      = 8,
    parameter int p_depth      = 8,
    parameter int p_depth_log2 = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_vld,
    input  logic [p_width-1:0] wr_dat,
    input  logic               rd_rdy,
    output logic [p_width-1:0] rd_dat,
    output logic               empty,
    output logic               full
);
    localparam logic [p_depth_log2:0] full_cnt = (p_depth_log2+1)'(p_depth);

    logic [p_width-1:0]      mem [p_depth];
    logic [p_depth_log2-1:0] wr_ptr, rd_ptr;
    logic [p_depth_log2:0]   cnt;
    logic                    do_wr, do_rd;

    assign empty  = (cnt == '0);
    assign full   = (cnt == full_cnt);
    assign do_wr  = wr_vld & ~full;
    assign do_rd  = rd_rdy & ~empty;
    assign rd_dat = mem[rd_ptr];

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module mm_st_ctx_arb #(
    parameter int p_st_bits          = `WORD_BITS,
    parameter int p_addr_bits        = `MEM_ADDR_BITS,
    parameter int p_ctx_num          = 4,
    parameter int p_ctx_log2         = 2,
    parameter int p_fifo_length      = 8,
    parameter int p_fifo_length_log2 = 3,
    parameter int p_tag_length       = 8,
    parameter int p_tag_length_log2  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [p_ctx_log2-1:0]  i_ctx_sel,
    input  logic                   i_lwst_start,
    input  logic                   i_read_req,
    input  logic                   i_write_req,
    input  logic [p_addr_bits-1:0] i_addr,
    input  logic [p_st_bits-1:0]   i_writedata,
    output logic                   o_req_ready,
    output logic [p_st_bits-1:0]   o_readdata,
    output logic                   o_valid,
    input  logic                   i_rd_ready,
    output logic                   o_write_mem_complete,
    output logic                   o_read_mem_complete,
    output logic [p_ctx_log2-1:0]  o_cmpl_ctx,
    output logic [p_addr_bits-1:0] o_addr,
    output logic [p_st_bits-1:0]   o_writedata,
    output logic                   o_read,
    output logic                   o_write,
    input  logic [p_st_bits-1:0]   i_readdata,
    input  logic                   i_readdatavalid,
    input  logic                   i_waitrequest
);
    // Request entry layout: {writedata, addr, rd}; a write is simply "not rd".
    localparam int ent_w = p_st_bits + p_addr_bits + 1;
    localparam logic [p_fifo_length_log2:0] credit_max = (p_fifo_length_log2+1)'(p_fifo_length);

    typedef enum logic {st_idle, st_hold} state_t;

    logic [p_ctx_num-1:0][ent_w-1:0]     req_head;
    logic [p_ctx_num-1:0][p_st_bits-1:0] ret_head;
    logic [p_ctx_num-1:0] req_empty, req_full, req_push, req_pop;
    logic [p_ctx_num-1:0] ret_empty, ret_full, ret_push, ret_pop;
    logic [p_ctx_num-1:0] elig;
    logic                  tag_empty, tag_full, tag_push, tag_pop;
    logic [p_ctx_log2-1:0] tag_head;
    state_t                state_q, state_d;
    logic [p_ctx_log2-1:0] grant_q, pick, cmd_ctx;
    logic                  any_elig, cmd_vld, accept, head_rd;
    logic [ent_w-1:0]      cmd_ent;

    for (genvar c = 0; c < p_ctx_num; c++) begin : g_ctx
        logic                         sel;
        logic                         rd_issue;
        // Return occupancy plus reads in flight: a read may only issue if its data has a guaranteed slot.
        logic [p_fifo_length_log2:0]  inflight;

        assign sel         = (i_ctx_sel == p_ctx_log2'(c));
        assign req_push[c] = sel & i_lwst_start & (i_read_req | i_write_req);
        assign req_pop[c]  = accept & (cmd_ctx == p_ctx_log2'(c));
        assign rd_issue    = req_pop[c] & head_rd;
        assign ret_push[c] = tag_pop & (tag_head == p_ctx_log2'(c));
        assign ret_pop[c]  = sel & i_rd_ready & ~ret_empty[c];
        assign elig[c]     = ~req_empty[c] &
                             (~req_head[c][0] | (~tag_full & ~ret_full[c] & (inflight < credit_max)));

        mm_st_ctx_arb_fifo #(
            .p_width(ent_w), .p_depth(p_fifo_length), .p_depth_log2(p_fifo_length_log2)
        ) u_req_fifo (
            .clk(clk), .rst(rst),
            .wr_vld(req_push[c]), .wr_dat({i_writedata, i_addr, i_read_req}),
            .rd_rdy(req_pop[c]), .rd_dat(req_head[c]),
            .empty(req_empty[c]), .full(req_full[c])
        );

        mm_st_ctx_arb_fifo #(
            .p_width(p_st_bits), .p_depth(p_fifo_length), .p_depth_log2(p_fifo_length_log2)
        ) u_ret_fifo (
            .clk(clk), .rst(rst),
            .wr_vld(ret_push[c]), .wr_dat(i_readdata),
            .rd_rdy(ret_pop[c]), .rd_dat(ret_head[c]),
            .empty(ret_empty[c]), .full(ret_full[c])
        );

        // Credit taken when a read is accepted, returned when its data leaves the return FIFO.
        always_ff @(posedge clk) begin
            if (rst) inflight <= '0;
            else begin
                case ({rd_issue, ret_pop[c]})
                    2'b10:   inflight <= inflight + 1'b1;
                    2'b01:   inflight <= inflight - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // In-order tag FIFO: remembers which context each outstanding read belongs to.
    mm_st_ctx_arb_fifo #(
        .p_width(p_ctx_log2), .p_depth(p_tag_length), .p_depth_log2(p_tag_length_log2)
    ) u_tag_fifo (
        .clk(clk), .rst(rst),
        .wr_vld(tag_push), .wr_dat(cmd_ctx),
        .rd_rdy(tag_pop), .rd_dat(tag_head),
        .empty(tag_empty), .full(tag_full)
    );

`ifdef MM_ST_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest eligible id is the last writer and wins.
    always_comb begin
        pick = '0;
        for (int i = p_ctx_num - 1; i >= 0; i--) begin
            if (elig[i]) pick = p_ctx_log2'(i);
        end
    end
`else
    logic [p_ctx_log2-1:0] rr_ptr;

    // Round-robin: scan offsets downward so the nearest eligible ctx at/after the pointer wins.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        for (int i = p_ctx_num - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= p_ctx_num) idx = idx - p_ctx_num;
            if (elig[idx]) pick = p_ctx_log2'(idx);
        end
    end

    // Pointer moves just past the context whose command was accepted.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (accept) rr_ptr <= (cmd_ctx == p_ctx_log2'(p_ctx_num - 1)) ? '0 : cmd_ctx + 1'b1;
    end
`endif

    assign any_elig = |elig;

    // Arbiter state register; the grant is captured when a stalled command must be held.
    always_ff @(posedge clk) begin
        if (rst) state_q <= st_idle;
        else     state_q <= state_d;
    end

    // Grant capture on entry to HOLD so the command stays frozen under waitrequest.
    always_ff @(posedge clk) begin
        if (rst) grant_q <= '0;
        else if (state_q == st_idle && any_elig && i_waitrequest) grant_q <= pick;
    end

    // Next state: stall into HOLD on waitrequest, leave HOLD once the slave accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_idle: if (any_elig && i_waitrequest) state_d = st_hold;
            st_hold: if (!i_waitrequest) state_d = st_idle;
            default: state_d = st_idle;
        endcase
    end

    // Command ownership: fresh pick in IDLE, captured grant in HOLD.
    always_comb begin
        cmd_vld = 1'b0;
        cmd_ctx = pick;
        case (state_q)
            st_idle: begin cmd_vld = any_elig; cmd_ctx = pick;    end
            st_hold: begin cmd_vld = 1'b1;     cmd_ctx = grant_q; end
            default: ;
        endcase
    end

    assign cmd_ent  = req_head[cmd_ctx];
    assign head_rd  = cmd_ent[0];
    assign accept   = cmd_vld & ~i_waitrequest;
    assign tag_push = accept & head_rd;
    assign tag_pop  = i_readdatavalid & ~tag_empty;

    assign o_read      = cmd_vld & head_rd;
    assign o_write     = cmd_vld & ~head_rd;
    assign o_addr      = cmd_vld ? cmd_ent[p_addr_bits:1] : '0;
    assign o_writedata = o_write ? cmd_ent[ent_w-1 -: p_st_bits] : '0;

    assign o_write_mem_complete = o_write & ~i_waitrequest;
    assign o_read_mem_complete  = tag_pop;
    assign o_cmpl_ctx           = tag_pop ? tag_head : (cmd_vld ? cmd_ctx : '0);

    assign o_req_ready = ~req_full[i_ctx_sel];
    assign o_valid     = ~ret_empty[i_ctx_sel];
    assign o_readdata  = o_valid ? ret_head[i_ctx_sel] : '0;
endmodule

// File: tb/tb_mm_st_ctx_arb.sv
module tb_mm_st_ctx_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_ctx_sel;
    logic        i_lwst_start, i_read_req, i_write_req;
    logic [31:0] i_addr, i_writedata;
    logic        o_req_ready;
    logic [31:0] o_readdata;
    logic        o_valid;
    logic        i_rd_ready;
    logic        o_write_mem_complete, o_read_mem_complete;
    logic [1:0]  o_cmpl_ctx;
    logic [31:0] o_addr, o_writedata;
    logic        o_read, o_write;
    logic [31:0] i_readdata;
    logic        i_readdatavalid, i_waitrequest;

    typedef struct {
        logic        rd;
        logic [1:0]  ctx;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t       exp_cmd [$];
    logic [1:0] exp_ret [$];
    cmd_t       mon_cmd;
    logic [1:0] mon_ret;
    int         n_checks = 0;
    int         n_fail   = 0;

    mm_st_ctx_arb #(
        .p_st_bits(32), .p_addr_bits(32), .p_ctx_num(4), .p_ctx_log2(2),
        .p_fifo_length(8), .p_fifo_length_log2(3), .p_tag_length(8), .p_tag_length_log2(3)
    ) dut (
        .clk(clk), .rst(rst),
        .i_ctx_sel(i_ctx_sel), .i_lwst_start(i_lwst_start),
        .i_read_req(i_read_req), .i_write_req(i_write_req),
        .i_addr(i_addr), .i_writedata(i_writedata),
        .o_req_ready(o_req_ready), .o_readdata(o_readdata), .o_valid(o_valid),
        .i_rd_ready(i_rd_ready),
        .o_write_mem_complete(o_write_mem_complete), .o_read_mem_complete(o_read_mem_complete),
        .o_cmpl_ctx(o_cmpl_ctx),
        .o_addr(o_addr), .o_writedata(o_writedata), .o_read(o_read), .o_write(o_write),
        .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid), .i_waitrequest(i_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic rd, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        cmd_t e;
        e.rd = rd; e.ctx = c; e.addr = a; e.data = d;
        exp_cmd.push_back(e);
    endtask

    // One strobe cycle on the LW/ST side for context c.
    task automatic push(input logic [1:0] c, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        i_ctx_sel = c; i_lwst_start = 1'b1; i_read_req = rd; i_write_req = wr;
        i_addr = a; i_writedata = d;
        tick();
        i_lwst_start = 1'b0; i_read_req = 1'b0; i_write_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_ctx_sel = '0; i_lwst_start = 0; i_read_req = 0; i_write_req = 0;
        i_addr = '0; i_writedata = '0; i_rd_ready = 0;
        i_readdata = '0; i_readdatavalid = 0; i_waitrequest = 0;
        exp_cmd.delete();
        exp_ret.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((exp_cmd.size() + exp_ret.size()) != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_cmd.size() + exp_ret.size()), 64'd0);
    endtask

    task automatic rdv(input logic [31:0] d);
        i_readdatavalid = 1'b1; i_readdata = d;
        tick();
        i_readdatavalid = 1'b0;
    endtask

    // Scoreboard side: compare every accepted command and every read completion against queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_read_mem_complete) begin
                if (exp_ret.size() == 0) chk("ret_unexpected", 64'(o_read_mem_complete), 64'd0);
                else begin
                    mon_ret = exp_ret.pop_front();
                    chk("ret_ctx", 64'(o_cmpl_ctx), 64'(mon_ret));
                end
            end
            if ((o_read | o_write) && !i_waitrequest) begin
                if (exp_cmd.size() == 0) chk("cmd_unexpected", 64'(o_read | o_write), 64'd0);
                else begin
                    mon_cmd = exp_cmd.pop_front();
                    chk("cmd_kind", 64'({o_read, o_write}), 64'({mon_cmd.rd, !mon_cmd.rd}));
                    chk("cmd_addr", 64'(o_addr), 64'(mon_cmd.addr));
                    if (!mon_cmd.rd) begin
                        chk("cmd_wdata", 64'(o_writedata), 64'(mon_cmd.data));
                        chk("wr_cmpl", 64'(o_write_mem_complete), 64'd1);
                        if (!o_read_mem_complete) chk("wr_cmpl_ctx", 64'(o_cmpl_ctx), 64'(mon_cmd.ctx));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_read",  64'(o_read), 64'd0);
        chk("rst_write", 64'(o_write), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_rdy",   64'(o_req_ready), 64'd1);
        chk("rst_cmpl",  64'({o_write_mem_complete, o_read_mem_complete}), 64'd0);
        chk("rst_addr",  64'(o_addr), 64'd0);
        tick();

        // 1: write held under waitrequest for 3 cycles, completes on the 4th
        i_waitrequest = 1'b1;
        exp_push(1'b0, 2'd2, 32'h10, 32'hCAFE);
        push(2'd2, 1'b0, 1'b1, 32'h10, 32'hCAFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_hold_wr",   64'(o_write), 64'd1);
            chk("t1_hold_addr", 64'(o_addr), 64'h10);
            chk("t1_hold_data", 64'(o_writedata), 64'hCAFE);
            chk("t1_no_cmpl",   64'(o_write_mem_complete), 64'd0);
            tick();
        end
        i_waitrequest = 1'b0;
        tick();
        @(negedge clk);
        chk("t1_dropped", 64'(o_write), 64'd0);
        drain("t1_drain", 5);

        // 2: three contexts with two writes each, issue order follows the arbitration policy
        do_reset();
        i_waitrequest = 1'b1;
`ifdef MM_ST_ARB_FIXED_PRIO_EN
        exp_push(0, 0, 32'h100, 32'h000); exp_push(0, 0, 32'h101, 32'h001);
        exp_push(0, 1, 32'h110, 32'h100); exp_push(0, 1, 32'h111, 32'h101);
        exp_push(0, 3, 32'h130, 32'h300); exp_push(0, 3, 32'h131, 32'h301);
`else
        exp_push(0, 0, 32'h100, 32'h000); exp_push(0, 1, 32'h110, 32'h100);
        exp_push(0, 3, 32'h130, 32'h300); exp_push(0, 0, 32'h101, 32'h001);
        exp_push(0, 1, 32'h111, 32'h101); exp_push(0, 3, 32'h131, 32'h301);
`endif
        for (int n = 0; n < 2; n++) begin
            push(2'd0, 0, 1, 32'h100 + 32'(n), 32'h000 + 32'(n));
            push(2'd1, 0, 1, 32'h110 + 32'(n), 32'h100 + 32'(n));
            push(2'd3, 0, 1, 32'h130 + 32'(n), 32'h300 + 32'(n));
        end
        i_waitrequest = 1'b0;
        drain("t2_drain", 20);

        // 3: reads from ctx1 and ctx3, data routed to each return FIFO in order
        do_reset();
        exp_push(1, 1, 32'h20, 32'h0);
        exp_push(1, 3, 32'h30, 32'h0);
        push(2'd1, 1, 0, 32'h20, 32'h0);
        push(2'd3, 1, 0, 32'h30, 32'h0);
        repeat (3) tick();
        exp_ret.push_back(2'd1);
        exp_ret.push_back(2'd3);
        rdv(32'h11);
        rdv(32'h33);
        drain("t3_drain", 5);
        i_ctx_sel = 2'd1;
        @(negedge clk);
        chk("t3_valid1", 64'(o_valid), 64'd1);
        chk("t3_data1",  64'(o_readdata), 64'h11);
        tick();
        i_ctx_sel = 2'd3;
        @(negedge clk);
        chk("t3_valid3", 64'(o_valid), 64'd1);
        chk("t3_data3",  64'(o_readdata), 64'h33);
        tick();
        i_rd_ready = 1'b1;
        tick();
        i_rd_ready = 1'b0;
        @(negedge clk);
        chk("t3_popped", 64'(o_valid), 64'd0);
        tick();

        // 4: full request FIFO, tag FIFO full, return credit exhausted
        do_reset();
        i_waitrequest = 1'b1;
        for (int n = 0; n < 8; n++) begin
            exp_push(1, 0, 32'h40 + 32'(n), 32'h0);
            push(2'd0, 1, 0, 32'h40 + 32'(n), 32'h0);
        end
        @(negedge clk);
        chk("t4_full", 64'(o_req_ready), 64'd0);
        push(2'd0, 1, 0, 32'h48, 32'h0);
        i_waitrequest = 1'b0;
        drain("t4_drain8", 20);
        repeat (2) tick();
        push(2'd1, 1, 0, 32'h50, 32'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("t4_tag_block", 64'(o_read), 64'd0);
        tick();
        exp_push(1, 1, 32'h50, 32'h0);
        for (int n = 0; n < 8; n++) exp_ret.push_back(2'd0);
        exp_ret.push_back(2'd1);
        for (int n = 0; n < 8; n++) rdv(32'hA0 + 32'(n));
        rdv(32'hB1);
        drain("t4_drain_ret", 5);
        i_ctx_sel = 2'd1;
        @(negedge clk);
        chk("t4_data_c1", 64'(o_readdata), 64'hB1);
        tick();
        i_ctx_sel = 2'd0;
        @(negedge clk);
        chk("t4_data_c0", 64'(o_readdata), 64'hA0);
        tick();
        i_rd_ready = 1'b1;
        tick();
        i_rd_ready = 1'b0;
        @(negedge clk);
        chk("t4_next_c0", 64'(o_readdata), 64'hA1);
        tick();
        exp_push(1, 0, 32'h60, 32'h0);
        push(2'd0, 1, 0, 32'h60, 32'h0);
        push(2'd0, 1, 0, 32'h61, 32'h0);
        repeat (4) tick();
        chk("t4_credit_issue", 64'(exp_cmd.size()), 64'd0);
        @(negedge clk);
        chk("t4_credit_block", 64'(o_read), 64'd0);
        tick();
        exp_push(1, 0, 32'h61, 32'h0);
        i_ctx_sel = 2'd0;
        i_rd_ready = 1'b1;
        tick();
        i_rd_ready = 1'b0;
        drain("t4_credit_release", 5);

        // 5: read and write strobed together -> read only
        do_reset();
        exp_push(1, 2, 32'h70, 32'h0);
        push(2'd2, 1, 1, 32'h70, 32'hDEAD);
        drain("t5_drain", 5);

        // 6: reset with three reads outstanding and a held write; late read data discarded
        do_reset();
        exp_push(1, 0, 32'h80, 32'h0);
        exp_push(1, 1, 32'h81, 32'h0);
        exp_push(1, 2, 32'h82, 32'h0);
        push(2'd0, 1, 0, 32'h80, 32'h0);
        push(2'd1, 1, 0, 32'h81, 32'h0);
        push(2'd2, 1, 0, 32'h82, 32'h0);
        drain("t6_issue", 5);
        i_waitrequest = 1'b1;
        push(2'd3, 0, 1, 32'h90, 32'h5);
        @(negedge clk);
        chk("t6_pre_write", 64'(o_write), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_waitrequest = 1'b0;
        @(negedge clk);
        chk("t6_rst_cmd",   64'({o_read, o_write}), 64'd0);
        chk("t6_rst_ready", 64'(o_req_ready), 64'd1);
        tick();
        for (int n = 0; n < 3; n++) begin
            i_readdatavalid = 1'b1; i_readdata = 32'hE0 + 32'(n);
            @(negedge clk);
            chk("t6_late_rdv", 64'(o_read_mem_complete), 64'd0);
            tick();
        end
        i_readdatavalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i_ctx_sel = 2'(c);
            @(negedge clk);
            chk("t6_ret_empty", 64'(o_valid), 64'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
